// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT spectrum post-processing blocks.
package fft_pkg;

  localparam int FFT_N_DEF = 1024;
  localparam int IDX_W_DEF = 10;
  localparam int PWR_W     = 33;

  // tdata carries {imag, real}, 16 bits each
  localparam int RE_LSB = 0;
  localparam int IM_LSB = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

endpackage

// File: rtl/fft_pwr_pipe.sv
// fft_pwr_pipe: 2-stage bin power pipeline, re^2 + im^2, with {idx, last, valid} riding alongside.
module fft_pwr_pipe
  import fft_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    in_vld,
  input  logic signed [15:0]      in_re,
  input  logic signed [15:0]      in_im,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic                    in_last,
  output logic                    out_vld,
  output logic [PWR_W-1:0]        out_pwr,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             last;
  } side_t;

  logic [STAGES:1]    vld_pipe;
  side_t              s1_side, s2_side;
  logic [31:0]        s1_sq_re, s1_sq_im;
  logic signed [31:0] re_x, im_x;

  // sign-extend before squaring so the 32-bit product is exact
  assign re_x = 32'(in_re);
  assign im_x = 32'(in_im);

  // valid shift register; bubbles travel through with the data
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
  end

  // stage 1: squares, loaded only on a valid beat
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_sq_re <= '0;
      s1_sq_im <= '0;
      s1_side  <= '0;
    end else if (in_vld) begin
      s1_sq_re <= re_x * re_x;
      s1_sq_im <= im_x * im_x;
      s1_side  <= '{idx: in_idx, last: in_last};
    end
  end

  // stage 2: 33-bit sum, worst case 2^31 so no saturation
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out_pwr <= '0;
      s2_side <= '0;
    end else if (vld_pipe[1]) begin
      out_pwr <= PWR_W'(s1_sq_re) + PWR_W'(s1_sq_im);
      s2_side <= s1_side;
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_idx  = s2_side.idx;
  assign out_last = s2_side.last;

endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame strongest-bin search over an FFT output stream,
// with tlast framing checks. Optional spectrum buffer under FFT_SPEC_BUF_EN.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int FFT_N   = FFT_N_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = 511
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [31:0]         s_axis_tdata,
  input  logic [15:0]         s_axis_tuser,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [IDX_W-1:0]    peak_idx,
  output logic [PWR_W-1:0]    peak_pwr,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                err_tlast_early,
  output logic                err_tlast_miss,
  input  logic [IDX_W-2:0]    rd_addr,
  output logic [PWR_W-1:0]    rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] in_idx;
  logic             beat, in_is_last_idx, in_close;
  logic             p_vld, p_last, p_close, p_in_range;
  logic [PWR_W-1:0] p_pwr;
  logic [IDX_W-1:0] p_idx;
  logic             unused_tuser;

  assign in_idx         = s_axis_tuser[IDX_W-1:0];
  assign unused_tuser   = ^s_axis_tuser[15:IDX_W];
  assign beat           = s_axis_tvalid & s_axis_tready;
  assign in_is_last_idx = (in_idx == LAST_IDX);
  assign in_close       = s_axis_tlast | in_is_last_idx;

  fft_pwr_pipe #(.IDX_W(IDX_W)) u_pwr (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_vld   (beat),
    .in_re    (s_axis_tdata[RE_LSB +: 16]),
    .in_im    (s_axis_tdata[IM_LSB +: 16]),
    .in_idx   (in_idx),
    .in_last  (s_axis_tlast),
    .out_vld  (p_vld),
    .out_pwr  (p_pwr),
    .out_idx  (p_idx),
    .out_last (p_last)
  );

  // the input stalls after the closing beat, so any closing beat leaving stage 2 ends the drain
  assign p_close    = p_last | (p_idx == LAST_IDX);
  assign p_in_range = (p_idx >= IDX_W'(MIN_BIN)) && (p_idx <= IDX_W'(MAX_BIN));

  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    result_valid  = 1'b0;
    case (state)
      IDLE: begin
        s_axis_tready = 1'b1;
        if (beat) state_nxt = in_close ? DRAIN : ACCUM;
      end
      ACCUM: begin
        s_axis_tready = 1'b1;
        if (beat && in_close) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (p_vld && p_close) state_nxt = RESULT;
      end
      RESULT: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // running max: cleared at frame start, strict compare keeps the lowest index on ties
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      peak_pwr <= '0;
      peak_idx <= '0;
    end else if (state == IDLE && beat) begin
      peak_pwr <= '0;
      peak_idx <= IDX_W'(MIN_BIN);
    end else if (p_vld && p_in_range && (p_pwr > peak_pwr)) begin
      peak_pwr <= p_pwr;
      peak_idx <= p_idx;
    end
  end

  // framing flags: cleared at frame start, captured from the closing beat
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_tlast_early <= 1'b0;
      err_tlast_miss  <= 1'b0;
    end else if (beat && in_close) begin
      err_tlast_early <= s_axis_tlast & ~in_is_last_idx;
      err_tlast_miss  <= in_is_last_idx & ~s_axis_tlast;
    end else if (state == IDLE && beat) begin
      err_tlast_early <= 1'b0;
      err_tlast_miss  <= 1'b0;
    end
  end

`ifdef FFT_SPEC_BUF_EN
  logic [PWR_W-1:0] spec_mem [FFT_N/2];

  // positive-half powers written at their bin; no reset on the array
  always_ff @(posedge sys_clk) begin
    if (p_vld && !p_idx[IDX_W-1]) spec_mem[p_idx[IDX_W-2:0]] <= p_pwr;
  end

  // registered read port, one cycle from rd_addr
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) rd_data <= '0;
    else         rd_data <= spec_mem[rd_addr];
  end
`else
  logic unused_rd;
  assign unused_rd = ^rd_addr;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: randomized frames checked against a per-frame reference model.
module tb_fft_peak_detect;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] s_axis_tdata;
  logic [15:0] s_axis_tuser;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [9:0]  peak_idx;
  logic [32:0] peak_pwr;
  logic        result_valid, result_ready;
  logic        err_tlast_early, err_tlast_miss;
  logic [8:0]  rd_addr;
  logic [32:0] rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    int                 idx;
    bit                 last;
  } beat_t;

  beat_t frame[$];

  fft_peak_detect dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .peak_idx(peak_idx), .peak_pwr(peak_pwr),
    .result_valid(result_valid), .result_ready(result_ready),
    .err_tlast_early(err_tlast_early), .err_tlast_miss(err_tlast_miss),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // reference: walk the beats up to the closing one, keep the strongest in-range bin
  task automatic model(output longint pwr, output int idx, output bit early, output bit miss);
    pwr = 0; idx = 1; early = 0; miss = 0;
    foreach (frame[i]) begin
      longint p;
      p = longint'(frame[i].re) * longint'(frame[i].re) + longint'(frame[i].im) * longint'(frame[i].im);
      if (frame[i].idx >= 1 && frame[i].idx <= 511 && p > pwr) begin
        pwr = p;
        idx = frame[i].idx;
      end
      if (frame[i].last || frame[i].idx == 1023) begin
        early = frame[i].last && frame[i].idx != 1023;
        miss  = !frame[i].last && frame[i].idx == 1023;
        break;
      end
    end
  endtask

  task automatic mk_frame(input int n, input int last_at, input bit rnd);
    frame.delete();
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.re   = rnd ? 16'($urandom) : 16'sd0;
      b.im   = rnd ? 16'($urandom) : 16'sd0;
      b.idx  = i;
      b.last = (i == last_at);
      frame.push_back(b);
    end
  endtask

  // present one beat, wait (bounded) for acceptance; returns at accept edge + 1
  task automatic push_beat(input beat_t b, output bit ok);
    s_axis_tdata  = {b.im, b.re};
    s_axis_tuser  = {6'($urandom), 10'(b.idx)};
    s_axis_tlast  = b.last;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge sys_clk);
      ok = s_axis_tready;
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input int hold);
    longint ep; int ei; bit ee, em, ok, stable; int lat;
    model(ep, ei, ee, em);
    foreach (frame[i]) begin
      while ($urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge sys_clk); #1;
      end
      push_beat(frame[i], ok);
      if (!ok) begin
        chk({tag, "_accept"}, 0, 1);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    lat = 0;
    do begin
      @(negedge sys_clk);
      lat++;
    end while (!result_valid && lat < 10);
    chk({tag, "_lat"},   lat, 3);
    chk({tag, "_idx"},   peak_idx, ei);
    chk({tag, "_pwr"},   peak_pwr, ep);
    chk({tag, "_early"}, err_tlast_early, ee);
    chk({tag, "_miss"},  err_tlast_miss, em);
    chk({tag, "_rdy"},   s_axis_tready, 0);
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge sys_clk);
        if (!result_valid || s_axis_tready || peak_idx != 10'(ei) || peak_pwr != 33'(ep)
            || err_tlast_early != ee || err_tlast_miss != em) stable = 1'b0;
      end
      chk({tag, "_hold"}, stable, 1);
    end
    result_ready = 1'b1;
    @(posedge sys_clk); #1;
    result_ready = 1'b0;
    @(negedge sys_clk);
    chk({tag, "_vld_clr"}, result_valid, 0);
    chk({tag, "_rdy_back"}, s_axis_tready, 1);
  endtask

  initial begin
    bit ok;
    sys_rst = 1'b1;
    s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    result_ready = 1'b0; rd_addr = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_rdy", s_axis_tready, 1);
    chk("rst_vld", result_valid, 0);
    chk("rst_idx", peak_idx, 0);
    chk("rst_pwr", peak_pwr, 0);
    chk("rst_err", {err_tlast_early, err_tlast_miss}, 0);
    chk("rst_rd",  rd_data, 0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // single strong bin
    mk_frame(1024, 1023, 0);
    frame[37].re = 16'sd1000;
    run_frame("f1", 0, 0);
    rd_addr = 9'd37;
    @(posedge sys_clk); #1;
`ifdef FFT_SPEC_BUF_EN
    chk("buf_rd37", rd_data, 1000000);
`else
    chk("buf_rd0", rd_data, 0);
`endif

    // DC excluded
    mk_frame(1024, 1023, 0);
    frame[0].re = 16'sd32767;
    frame[200].re = 16'sd100;
    run_frame("dc", 0, 0);

    // full-scale tie, lowest index wins
    mk_frame(1024, 1023, 0);
    frame[50].re = -16'sd32768; frame[50].im = -16'sd32768;
    frame[60].re = -16'sd32768; frame[60].im = -16'sd32768;
    run_frame("tie", 0, 0);

    // framing errors
    mk_frame(512, 511, 1);
    run_frame("early", 0, 0);
    mk_frame(1024, -1, 1);
    run_frame("miss", 0, 0);

    // random gaps and a stalled consumer, then a back-to-back frame
    mk_frame(1024, 1023, 1);
    run_frame("gap", 30, 20);
    mk_frame(1024, 1023, 1);
    run_frame("f2", 10, 3);

    // out-of-order indices, tlast on an arbitrary beat
    frame.delete();
    for (int i = 0; i < 200; i++) begin
      beat_t b;
      b.re = 16'($urandom); b.im = 16'($urandom);
      b.idx = $urandom_range(1022); b.last = (i == 199);
      frame.push_back(b);
    end
    run_frame("shuf", 5, 0);

    // reset mid-frame
    mk_frame(1024, 1023, 1);
    for (int i = 0; i < 300; i++) begin
      push_beat(frame[i], ok);
      if (!ok) break;
    end
    chk("mid_accept", ok, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("mid_rdy", s_axis_tready, 1);
    chk("mid_pwr", peak_pwr, 0);
    chk("mid_idx", peak_idx, 0);
    chk("mid_vld", result_valid, 0);
    s_axis_tvalid = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    mk_frame(1024, 1023, 1);
    run_frame("post_rst", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
